// File: rtl/counter_up_down_if.sv
// Control and status bundle for the up/down event counter.
// The controller drives direction/enable; consumers read count and wrap.
interface counter_up_down_if #(
    parameter int WIDTH = 8
);
    logic             up_down;
    logic             count_en;
    logic [WIDTH-1:0] count8;
    logic             carry;

    modport master (
        output up_down,
        output count_en,
        input  count8,
        input  carry
    );

    modport slave (
        input  up_down,
        input  count_en,
        output count8,
        output carry
    );
endinterface

// File: rtl/counter_up_down.sv
// Up/down binary counter with enable and a registered one-cycle wrap pulse.
// Both outputs come straight from flops; reset clears them asynchronously.
module counter_up_down #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    counter_up_down_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             carry_q;
    logic             carry_nxt;
    logic             inc;
    logic             dec;

    assign inc = bus.count_en & bus.up_down;
    assign dec = bus.count_en & ~bus.up_down;

    // The wrap test looks at the current value with the direction sampled
    // on this edge, so a direction flip never costs a cycle.
    always_comb begin
        count_nxt = count_q;
        carry_nxt = 1'b0;
        unique case (1'b1)
            inc: begin
                count_nxt = count_q + ONE;
                carry_nxt = (count_q == MAX);
            end
            dec: begin
                count_nxt = count_q - ONE;
                carry_nxt = (count_q == '0);
            end
            default: begin
                count_nxt = count_q;
                carry_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_nxt;
            carry_q <= carry_nxt;
        end
    end

    assign bus.count8 = count_q;
    assign bus.carry  = carry_q;
endmodule

// File: tb/tb_counter_up_down.sv
// Directed bench for counter_up_down: a vector table plus
// hand-written multi-cycle sequences for wrap, pause and reset.
module tb_counter_up_down;
    localparam int WIDTH = 8;

    typedef struct {
        logic       en;
        logic       dir;
        logic [7:0] exp_count;
        logic       exp_carry;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    counter_up_down_if #(.WIDTH(WIDTH)) bus ();

    counter_up_down #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic en, input logic dir);
        bus.count_en = en;
        bus.up_down  = dir;
        @(posedge clk);
        #1;
    endtask

    // Async assert between edges, hold two clocks, release on a negedge.
    task automatic do_reset(input string name);
        bus.count_en = 1'b1;
        bus.up_down  = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk({name, " async count"}, 32'(bus.count8), 0);
        chk({name, " async carry"}, 32'(bus.carry), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk({name, " held count"}, 32'(bus.count8), 0);
            chk({name, " held carry"}, 32'(bus.carry), 0);
        end
        bus.count_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk({name, " after release"}, 32'(bus.count8), 0);
    endtask

    initial begin
        vec_t vt[13];
        int   pulses;

        vt[0]  = '{1'b1, 1'b1, 8'd1,   1'b0};
        vt[1]  = '{1'b1, 1'b1, 8'd2,   1'b0};
        vt[2]  = '{1'b0, 1'b0, 8'd2,   1'b0};
        vt[3]  = '{1'b1, 1'b0, 8'd1,   1'b0};
        vt[4]  = '{1'b1, 1'b0, 8'd0,   1'b0};
        vt[5]  = '{1'b1, 1'b0, 8'd255, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 8'd255, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 8'd0,   1'b1};
        vt[8]  = '{1'b1, 1'b1, 8'd1,   1'b0};
        vt[9]  = '{1'b1, 1'b0, 8'd0,   1'b0};
        vt[10] = '{1'b1, 1'b0, 8'd255, 1'b1};
        vt[11] = '{1'b1, 1'b1, 8'd0,   1'b1};
        vt[12] = '{1'b1, 1'b1, 8'd1,   1'b0};

        n_vec        = 0;
        n_err        = 0;
        reset_n      = 1'b1;
        bus.count_en = 1'b0;
        bus.up_down  = 1'b1;

        // Put the counter in an arbitrary state before the first reset
        repeat (3) @(posedge clk);
        #1;
        do_reset("t1");

        for (int i = 0; i < 13; i++) begin
            tick(vt[i].en, vt[i].dir);
            chk($sformatf("vec%0d count", i), 32'(bus.count8),
                32'(vt[i].exp_count));
            chk($sformatf("vec%0d carry", i), 32'(bus.carry),
                32'(vt[i].exp_carry));
        end

        // Up count 30 edges, then pause, then 300 more
        do_reset("t2");
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b1);
            if (bus.carry !== 1'b0) pulses++;
        end
        chk("t2 count", 32'(bus.count8), 30);
        chk("t2 carry pulses", pulses, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1);
            chk("t3 paused", 32'(bus.count8), 30);
        end
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b1);
            if (bus.carry === 1'b1) begin
                pulses++;
                chk("t3 wrap value", 32'(bus.count8), 0);
            end
        end
        chk("t3 count", 32'(bus.count8), 74);
        chk("t3 carry pulses", pulses, 1);

        // Down from reset: immediate borrow
        do_reset("t4");
        tick(1'b1, 1'b0);
        chk("t4 first count", 32'(bus.count8), 255);
        chk("t4 first carry", 32'(bus.carry), 1);
        tick(1'b1, 1'b0);
        chk("t4 second count", 32'(bus.count8), 254);
        chk("t4 second carry", 32'(bus.carry), 0);
        for (int i = 2; i < 30; i++) tick(1'b1, 1'b0);
        chk("t4 count", 32'(bus.count8), 226);

        // Direction flip without a dead cycle
        do_reset("t5");
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        chk("t5 at five", 32'(bus.count8), 5);
        for (int e = 4; e >= 0; e--) begin
            tick(1'b1, 1'b0);
            chk($sformatf("t5 down to %0d", e), 32'(bus.count8), e);
            chk("t5 no carry", 32'(bus.carry), 0);
        end
        tick(1'b1, 1'b0);
        chk("t5 borrow count", 32'(bus.count8), 255);
        chk("t5 borrow carry", 32'(bus.carry), 1);

        // Reset mid-pulse must drop carry at once
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 midpulse count", 32'(bus.count8), 0);
        chk("t6 midpulse carry", 32'(bus.carry), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-count at 200
        for (int i = 0; i < 200; i++) tick(1'b1, 1'b1);
        chk("t6 at 200", 32'(bus.count8), 200);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 async count", 32'(bus.count8), 0);
        chk("t6 async carry", 32'(bus.carry), 0);
        bus.count_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick(1'b1, 1'b1);
            chk($sformatf("t6 resume %0d", e), 32'(bus.count8), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
